nv_nvdla_sdp_core_mc_fsm: RTL and testbench
===========================================

Name: nv_nvdla_sdp_core_mc_fsm

Overview:
Parametrised, multi-channel successor of the single-bit SDP core-enable FSM. It replaces the sticky idle/active flag with one independent four-state controller per channel: IDLE, RUN, DRAIN and DONE. Each controller has a stall-aware drain counter and an explicit clear. It sits between the SDP register/config logic, which drives the per-channel core_wen, core_done and core_clr strobes, and the SDP datapath, which consumes the one-hot state vectors and the busy/done status.

Parameters:
NUM_CH, 4, number of independent channel FSMs (1..16).
DRAIN_W, 4, width of the per-channel drain counter.
DRAIN_CYC, 8, drain cycles after core_done before DONE (0..2^DRAIN_W-1).

Ports:
nvdla_core_clk  input  1  core clock; all state changes on its rising edge.
nvdla_core_rstn  input  1  reset, asynchronous, active-low.
core_wen  input  NUM_CH  per-channel start strobe (one cycle or level).
core_done  input  NUM_CH  per-channel datapath-finished strobe.
core_clr  input  NUM_CH  per-channel synchronous return-to-IDLE.
stall  input  1  global stall; freezes all drain counters.
fsm_output  output  4*NUM_CH  one-hot state of channel i in bits [4i+3:4i]: IDLE=0001, RUN=0010, DRAIN=0100, DONE=1000.
busy  output  NUM_CH  channel in RUN or DRAIN.
all_done  output  1  every channel in DONE.

Behaviour:
- Reset (async assert, sync release): every channel goes to IDLE and every drain counter to 0.
  - fsm_output = {NUM_CH{4'b0001}}, busy = 0, all_done = 0.
- State registers are the only flops apart from the counters. All outputs are decoded combinationally from registered state, so an input change is visible on the outputs 1 cycle later.
- Per-channel transitions, evaluated independently each cycle in priority order:
  1. core_clr=1 in any state -> IDLE, counter cleared. Overrides all other inputs in the same cycle.
  2. IDLE:
     - core_wen=1 -> RUN.
     - core_done is ignored in IDLE, including when it arrives together with core_wen.
  3. RUN:
     - core_done=1 and DRAIN_CYC>0 -> DRAIN, counter loaded with DRAIN_CYC-1.
     - core_done=1 and DRAIN_CYC=0 -> DONE directly.
     - core_wen in RUN is ignored (sticky, as in the legacy block).
  4. DRAIN:
     - stall=1 -> hold state and counter.
     - stall=0 and counter=0 -> DONE.
     - stall=0 and counter>0 -> counter decrements by 1.
     - core_wen and core_done are ignored.
  5. DONE:
     - core_wen=1 -> RUN (re-arm without clear).
     - Otherwise hold.
- Drain timing: with stall low throughout, DONE is entered exactly DRAIN_CYC cycles after the edge that entered DRAIN. Each stalled cycle extends this by one.
- Counter arithmetic is unsigned DRAIN_W bits. It never wraps, because decrement only happens when the counter is nonzero.
- busy[i] = RUN|DRAIN. all_done = AND over channels of DONE. all_done drops in the cycle after any channel is cleared or re-armed.
- Illegal state encodings are unreachable. If one is ever decoded, the channel's next state is IDLE.
- Reset asserted mid-RUN or mid-DRAIN returns the channel to IDLE immediately and asynchronously. There is no pending-done memory.

Test Plan:
- Reset, then core_wen[0]=1 for 1 cycle -> next cycle fsm_output[3:0]=0010 and busy=0001; channels 1..3 remain 0001.
- Default parameters (DRAIN_CYC=8): channel 0 in RUN, pulse core_done[0], no stall -> DRAIN for exactly 8 cycles, then fsm_output[3:0]=1000 and busy[0]=0.
- Same drain with stall=1 for 3 cycles mid-drain -> DONE reached after 11 cycles; counter value holds during the stall.
- All four channels started at different cycles and each driven to DONE -> all_done=1 only after the last one. Then core_clr[2]=1 -> next cycle channel 2 reads 0001 and all_done=0.
- Simultaneous events:
  - core_clr and core_wen together on a DONE channel -> IDLE.
  - core_wen and core_done together on an IDLE channel -> RUN.
  - core_wen alone on a DONE channel -> RUN.
- DRAIN_CYC=0 build: core_done in RUN -> DONE on the next edge. Separately, rstn low during DRAIN -> immediate 0001, counter 0, and a new core_wen after release starts a normal RUN.

Source files
------------

// File: rtl/nv_nvdla_sdp_core_mc_fsm.sv
// ---------------------------------------------------------------------------
// nv_nvdla_sdp_core_mc_fsm
//
// Multi-channel SDP core-enable controller. Each of NUM_CH channels runs an
// independent IDLE -> RUN -> DRAIN -> DONE sequence. A stall-aware drain
// counter delays DONE by DRAIN_CYC cycles after core_done, and a per-channel
// clear returns the channel to IDLE.
//
// Ports:
//   nvdla_core_clk   core clock, rising edge
//   nvdla_core_rstn  asynchronous active-low reset
//   core_wen         per-channel start / re-arm strobe
//   core_done        per-channel datapath-finished strobe
//   core_clr         per-channel synchronous return-to-IDLE (highest priority)
//   stall            global stall, freezes every drain counter
//   fsm_output       one-hot state per channel, bits [4i+3:4i]
//                    (IDLE=0001, RUN=0010, DRAIN=0100, DONE=1000)
//   busy             per-channel RUN or DRAIN
//   all_done         every channel in DONE
// ---------------------------------------------------------------------------
module nv_nvdla_sdp_core_mc_fsm #(
  parameter int NUM_CH    = 4,
  parameter int DRAIN_W   = 4,
  parameter int DRAIN_CYC = 8
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic [NUM_CH-1:0]     core_wen,
  input  logic [NUM_CH-1:0]     core_done,
  input  logic [NUM_CH-1:0]     core_clr,
  input  logic                  stall,
  output logic [4*NUM_CH-1:0]   fsm_output,
  output logic [NUM_CH-1:0]     busy,
  output logic                  all_done
);

  // One-hot encoding: the state register drives fsm_output directly.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  // The counter counts down to zero and DONE follows on the next unstalled
  // edge, so it is loaded with DRAIN_CYC-1 to give exactly DRAIN_CYC cycles.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
    (DRAIN_CYC > 0) ? DRAIN_W'(DRAIN_CYC - 1) : '0;
  localparam bit HAS_DRAIN = (DRAIN_CYC > 0);

  logic [NUM_CH-1:0] done_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t             state;
      logic [DRAIN_W-1:0] cnt;

      always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (core_clr[gi]) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            // core_done is ignored here, even alongside core_wen.
            IDLE: begin
              if (core_wen[gi]) state <= RUN;
            end
            // core_wen is sticky in RUN and ignored.
            RUN: begin
              if (core_done[gi]) begin
                if (HAS_DRAIN) begin
                  state <= DRAIN;
                  cnt   <= DRAIN_LOAD;
                end else begin
                  state <= DONE;
                end
              end
            end
            // Decrement only when nonzero, so the counter never wraps.
            DRAIN: begin
              if (!stall) begin
                if (cnt == '0) state <= DONE;
                else           cnt   <= cnt - 1'b1;
              end
            end
            DONE: begin
              if (core_wen[gi]) state <= RUN;
            end
            // Any non-one-hot value recovers to IDLE.
            default: begin
              state <= IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end

      assign fsm_output[4*gi +: 4] = state;
      assign busy[gi]              = (state == RUN) || (state == DRAIN);
      assign done_vec[gi]          = (state == DONE);
    end
  endgenerate

  assign all_done = &done_vec;

endmodule

// File: tb/tb_nv_nvdla_sdp_core_mc_fsm.sv
module tb_nv_nvdla_sdp_core_mc_fsm;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int N0 = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] wen = '0, done = '0, clr = '0;
  logic stall = 1'b0;

  logic [4*N-1:0]  fo;
  logic [N-1:0]    busy;
  logic            ad;
  logic [4*N0-1:0] fo0;
  logic [N0-1:0]   busy0;
  logic            ad0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nv_nvdla_sdp_core_mc_fsm #(.NUM_CH(N), .DRAIN_W(4), .DRAIN_CYC(D)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .core_wen(wen), .core_done(done), .core_clr(clr), .stall(stall),
    .fsm_output(fo), .busy(busy), .all_done(ad));

  nv_nvdla_sdp_core_mc_fsm #(.NUM_CH(N0), .DRAIN_W(4), .DRAIN_CYC(0)) dut0 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .core_wen(wen[N0-1:0]), .core_done(done[N0-1:0]), .core_clr(clr[N0-1:0]),
    .stall(stall),
    .fsm_output(fo0), .busy(busy0), .all_done(ad0));

  // Reference model: phase 0=idle 1=run 2=drain 3=done; rem = unstalled
  // cycles still to spend in drain before done.
  int ph[N], rem[N], ph0[N0];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin ph[i] <= 0; rem[i] <= 0; end
      for (int i = 0; i < N0; i++) ph0[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin ph[i] <= 0; rem[i] <= 0; end
        else if (ph[i] == 0 && wen[i]) ph[i] <= 1;
        else if (ph[i] == 1 && done[i]) begin ph[i] <= 2; rem[i] <= D; end
        else if (ph[i] == 2 && !stall) begin
          rem[i] <= rem[i] - 1;
          if (rem[i] == 1) ph[i] <= 3;
        end
        else if (ph[i] == 3 && wen[i]) ph[i] <= 1;
      end
      for (int i = 0; i < N0; i++) begin
        if (clr[i]) ph0[i] <= 0;
        else if (ph0[i] == 0 && wen[i]) ph0[i] <= 1;
        else if (ph0[i] == 1 && done[i]) ph0[i] <= 3;
        else if (ph0[i] == 3 && wen[i]) ph0[i] <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      logic [4*N-1:0] efo; logic [N-1:0] eb; logic ea;
      logic [4*N0-1:0] efo0; logic [N0-1:0] eb0; logic ea0;
      efo = '0; eb = '0; ea = 1'b1;
      for (int i = 0; i < N; i++) begin
        efo[4*i +: 4] = 4'(1 << ph[i]);
        eb[i] = (ph[i] == 1 || ph[i] == 2);
        if (ph[i] != 3) ea = 1'b0;
      end
      efo0 = '0; eb0 = '0; ea0 = 1'b1;
      for (int i = 0; i < N0; i++) begin
        efo0[4*i +: 4] = 4'(1 << ph0[i]);
        eb0[i] = (ph0[i] == 1);
        if (ph0[i] != 3) ea0 = 1'b0;
      end
      chk("model_fsm_output", 32'(fo), 32'(efo));
      chk("model_busy", 32'(busy), 32'(eb));
      chk("model_all_done", 32'(ad), 32'(ea));
      chk("model0_fsm_output", 32'(fo0), 32'(efo0));
      chk("model0_busy", 32'(busy0), 32'(eb0));
      chk("model0_all_done", 32'(ad0), 32'(ea0));
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Pulse the given strobes for exactly one sampling edge.
  task automatic pulse(input logic [N-1:0] w, input logic [N-1:0] d, input logic [N-1:0] c);
    wen = w; done = d; clr = c;
    step();
    wen = '0; done = '0; clr = '0;
  endtask

  // Pulse core_done on channel 0 and count edges until it reads DONE.
  // stall is raised after edge 2 and dropped after edge 2+nstall.
  task automatic measure_drain(input string name, input int nstall, input int expect_cyc);
    int cnt;
    pulse('0, 4'b0001, '0);
    chk({name, "_in_drain"}, 32'(fo[3:0]), 32'h4);
    cnt = 0;
    while (fo[3:0] != 4'b1000 && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
      if (nstall > 0 && cnt == 2) stall = 1'b1;
      if (nstall > 0 && cnt == 2 + nstall) stall = 1'b0;
    end
    stall = 1'b0;
    #1;
    chk({name, "_cycles"}, 32'(cnt), 32'(expect_cyc));
    chk({name, "_busy0"}, 32'(busy[0]), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("reset_fsm_output", 32'(fo), 32'h1111);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_all_done", 32'(ad), 32'h0);
    chk("reset_fsm_output0", 32'(fo0), 32'h11);
    step();

    pulse(4'b0001, '0, '0);
    chk("start_ch0", 32'(fo), 32'h1112);
    chk("start_busy", 32'(busy), 32'h1);

    measure_drain("drain8", 0, 8);
    pulse(4'b0001, '0, '0);
    chk("rearm_ch0", 32'(fo[3:0]), 32'h2);
    measure_drain("drain_stall3", 3, 11);

    // Start channels 1..3 at different cycles, then finish them staggered.
    pulse(4'b0010, '0, '0);
    step();
    pulse(4'b0100, '0, '0);
    pulse(4'b1000, '0, '0);
    pulse('0, 4'b0010, '0);
    step();
    pulse('0, 4'b0100, '0);
    repeat (3) step();
    pulse('0, 4'b1000, '0);
    repeat (6) step();
    chk("before_last_all_done", 32'(ad), 32'h0);
    repeat (3) step();
    chk("all_done_set", 32'(ad), 32'h1);
    chk("all_done_fo", 32'(fo), 32'h8888);
    pulse('0, '0, 4'b0100);
    chk("clr2_fo", 32'(fo[11:8]), 32'h1);
    chk("clr2_all_done", 32'(ad), 32'h0);

    // ch3 DONE: clr+wen -> IDLE; ch2 IDLE: wen+done -> RUN; ch1 DONE: wen -> RUN.
    pulse(4'b1110, 4'b0100, 4'b1000);
    chk("clr_wins", 32'(fo[15:12]), 32'h1);
    chk("idle_wen_done", 32'(fo[11:8]), 32'h2);
    chk("done_rearm", 32'(fo[7:4]), 32'h2);

    // Zero-drain build, and the main build entering DRAIN on the same pulse.
    pulse('0, '0, 4'b1111);
    pulse(4'b0001, '0, '0);
    pulse('0, 4'b0001, '0);
    chk("nodrain_done", 32'(fo0[3:0]), 32'h8);
    chk("drain_entered", 32'(fo[3:0]), 32'h4);

    // Asynchronous reset in the middle of a drain.
    step();
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_fo", 32'(fo), 32'h1111);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_fo0", 32'(fo0), 32'h11);
    step();
    rstn = 1'b1;
    step();
    pulse(4'b0001, '0, '0);
    chk("post_rst_run", 32'(fo[3:0]), 32'h2);
    measure_drain("post_rst_drain", 0, 8);

    // Randomised traffic checked every cycle by the model comparison.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        wen[i]  = ($urandom % 4) == 0;
        done[i] = ($urandom % 4) == 0;
        clr[i]  = ($urandom % 40) == 0;
      end
      stall = ($urandom % 4) == 0;
      step();
    end
    wen = '0; done = '0; clr = '0; stall = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
